// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode and FSM state encodings shared by the universal shift register.
// Optional feature macro: SHIFT_REG_ASR_EN (mode 110 becomes arithmetic right shift).
package shift_reg_pkg;
  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
  // Modes that may run as a multi-step sequence; ASR only when it is built in.
  function automatic logic is_multi(mode_e m);
`ifdef SHIFT_REG_ASR_EN
    return m >= MODE_SHL && m <= MODE_ASR;
`else
    return m >= MODE_SHL && m <= MODE_ROR;
`endif
  endfunction
endpackage

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control/data bundle of the universal shift register.
// master drives sclr/en/start/mode/amt/D/sin_l/sin_r and observes Q/sout_l/sout_r/busy/done;
// slave is the register side.
interface univ_shift_reg_if #(parameter int WIDTH = 8);
  localparam int AMT_W = $clog2(WIDTH + 1);
  logic             sclr;
  logic             en;
  logic             start;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] D;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] Q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;
  modport master (output sclr, en, start, mode, amt, D, sin_l, sin_r,
                  input  Q, sout_l, sout_r, busy, done);
  modport slave  (input  sclr, en, start, mode, amt, D, sin_l, sin_r,
                  output Q, sout_l, sout_r, busy, done);
endinterface

// File: rtl/shift_reg_step.sv
// shift_reg_step: combinational one-step next value of the register for a given mode.
// Ports: i_q current value, i_mode operation, i_sin_l/i_sin_r serial inputs, i_d load data, o_q next value.
// Macro SHIFT_REG_ASR_EN enables the arithmetic right shift for MODE_ASR.
module shift_reg_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  mode_e            i_mode,
  input  logic             i_sin_l,
  input  logic             i_sin_r,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  always_comb begin
    o_q = i_q;
    case (i_mode)
      MODE_LOAD: o_q = i_d;
      MODE_SHL:  o_q = {i_q[WIDTH-2:0], i_sin_r};
      MODE_SHR:  o_q = {i_sin_l, i_q[WIDTH-1:1]};
      MODE_ROL:  o_q = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
      MODE_ROR:  o_q = {i_q[0], i_q[WIDTH-1:1]};
`ifdef SHIFT_REG_ASR_EN
      MODE_ASR:  o_q = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
`endif
      default:   o_q = i_q;
    endcase
  end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal register with load, clear, shift/rotate and shift-by-N sequencer.
// Ports: clk rising-edge clock, clr_n async active-low reset, bus (slave) carrying
// sclr/en/start/mode/amt/D/sin_l/sin_r in and Q/sout_l/sout_r/busy/done out.
// Macro SHIFT_REG_ASR_EN: mode 110 is arithmetic right shift; otherwise it behaves as HOLD.
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              clr_n,
  univ_shift_reg_if.slave  bus
);
  localparam int AMT_W = $clog2(WIDTH + 1);
  state_e           r_state, w_state;
  mode_e            r_mode, w_mode, w_in_mode, w_step_mode;
  logic [AMT_W-1:0] r_cnt, w_cnt, w_amt;
  logic [WIDTH-1:0] r_q, w_q, w_q_step;
  logic             r_done, w_done;
  assign w_in_mode   = mode_e'(bus.mode);
  // A running sequence keeps stepping with the mode captured at start.
  assign w_step_mode = r_state == ST_RUN ? r_mode : w_in_mode;
  assign w_amt       = bus.amt > AMT_W'(WIDTH) ? AMT_W'(WIDTH) : bus.amt;
  shift_reg_step #(.WIDTH(WIDTH)) u_step (
    .i_q    (r_q),
    .i_mode (w_step_mode),
    .i_sin_l(bus.sin_l),
    .i_sin_r(bus.sin_r),
    .i_d    (bus.D),
    .o_q    (w_q_step)
  );
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_HOLD;
      r_cnt   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_mode  <= w_mode;
      r_cnt   <= w_cnt;
      r_q     <= w_q;
      r_done  <= w_done;
    end
  end
  always_comb begin
    w_state = r_state;
    w_mode  = r_mode;
    w_cnt   = r_cnt;
    w_q     = r_q;
    w_done  = 1'b0;
    if (bus.sclr) begin
      w_q     = '0;
      w_state = ST_IDLE;
      w_cnt   = '0;
    end else if (r_state == ST_RUN) begin
      w_q   = w_q_step;
      w_cnt = r_cnt - AMT_W'(1);
      if (r_cnt == AMT_W'(1)) begin
        w_state = ST_IDLE;
        w_done  = 1'b1;
      end
    end else if (bus.start) begin
      if (is_multi(w_in_mode) && w_amt != '0) begin
        w_state = ST_RUN;
        w_mode  = w_in_mode;
        w_cnt   = w_amt;
      end else begin
        // Zero-step start: only LOAD changes Q, everything else holds.
        w_q    = w_in_mode == MODE_LOAD ? bus.D : r_q;
        w_done = 1'b1;
      end
    end else if (bus.en) begin
      w_q = w_q_step;
    end
  end
  assign bus.Q      = r_q;
  assign bus.sout_l = r_q[WIDTH-1];
  assign bus.sout_r = r_q[0];
  assign bus.busy   = r_state == ST_RUN;
  assign bus.done   = r_done;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: vector table, corner sequences and random run against an arithmetic model.
module tb_univ_shift_reg;
  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  univ_shift_reg_if #(.WIDTH(W)) bus ();
  univ_shift_reg #(.WIDTH(W)) dut (.clk(clk), .clr_n(clr_n), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic       sclr, en, start;
    logic [2:0] mode;
    logic [2:0] amt;
    logic [3:0] d;
    logic       sl, sr;
    logic [3:0] q;
    logic       busy, done;
  } vec_t;
  vec_t tv[$];
  int m_q, m_left, m_mode;
  logic m_done;
  function automatic vec_t v(logic sclr, logic en, logic start, logic [2:0] mode, logic [2:0] amt,
                             logic [3:0] d, logic sl, logic sr, logic [3:0] q, logic busy, logic done);
    vec_t r;
    r.sclr = sclr; r.en = en; r.start = start; r.mode = mode; r.amt = amt; r.d = d;
    r.sl = sl; r.sr = sr; r.q = q; r.busy = busy; r.done = done;
    return r;
  endfunction
  function automatic int step(int q, int mode, int sl, int sr, int d);
    case (mode)
      1: return d;
      2: return ((q << 1) | sr) & MASK;
      3: return (q >> 1) | (sl << (W - 1));
      4: return ((q << 1) | (q >> (W - 1))) & MASK;
      5: return (q >> 1) | ((q & 1) << (W - 1));
`ifdef SHIFT_REG_ASR_EN
      6: return (q >> 1) | (q & (1 << (W - 1)));
`endif
      default: return q;
    endcase
  endfunction
  function automatic bit multi_mode(int mode);
`ifdef SHIFT_REG_ASR_EN
    return mode >= 2 && mode <= 6;
`else
    return mode >= 2 && mode <= 5;
`endif
  endfunction
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drv(logic sclr, logic en, logic start, logic [2:0] mode, logic [2:0] amt,
                     logic [3:0] d, logic sl, logic sr);
    bus.sclr = sclr; bus.en = en; bus.start = start; bus.mode = mode;
    bus.amt = amt; bus.D = d; bus.sin_l = sl; bus.sin_r = sr;
  endtask
  task automatic model_reset();
    m_q = 0; m_left = 0; m_mode = 0; m_done = 1'b0;
  endtask
  // Advance one edge; the model consumes the inputs that were present at that edge.
  task automatic tick();
    int n;
    @(posedge clk);
    m_done = 1'b0;
    if (bus.sclr) begin
      m_q = 0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_q = step(m_q, m_mode, int'(bus.sin_l), int'(bus.sin_r), int'(bus.D));
      m_left--;
      m_done = m_left == 0;
    end else if (bus.start) begin
      n = int'(bus.amt) > W ? W : int'(bus.amt);
      if (multi_mode(int'(bus.mode)) && n > 0) begin
        m_mode = int'(bus.mode);
        m_left = n;
      end else begin
        m_q = bus.mode == 3'd1 ? int'(bus.D) : m_q;
        m_done = 1'b1;
      end
    end else if (bus.en) begin
      m_q = step(m_q, int'(bus.mode), int'(bus.sin_l), int'(bus.sin_r), int'(bus.D));
    end
    #1;
  endtask
  task automatic chk_state(string name, logic [3:0] q, logic busy, logic done);
    chk({name, ".Q"}, 8'(bus.Q), 8'(q));
    chk({name, ".busy"}, 8'(bus.busy), 8'(busy));
    chk({name, ".done"}, 8'(bus.done), 8'(done));
  endtask
  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 4'b0000, 0, 0);
    chk("reset.sout_l", 8'(bus.sout_l), 8'd0);
    chk("reset.sout_r", 8'(bus.sout_r), 8'd0);
    @(negedge clk);
    clr_n = 1'b1;
    //       sclr en st mode    amt  d        sl sr   q        busy done
    tv.push_back(v(0, 1, 0, 3'd1, 0, 4'b1010, 0, 0, 4'b1010, 0, 0));
    tv.push_back(v(0, 0, 0, 3'd1, 0, 4'b1111, 0, 0, 4'b1010, 0, 0));
    tv.push_back(v(1, 1, 0, 3'd1, 0, 4'b1111, 0, 0, 4'b0000, 0, 0));
    tv.push_back(v(0, 1, 0, 3'd1, 0, 4'b1001, 0, 0, 4'b1001, 0, 0));
    tv.push_back(v(0, 1, 0, 3'd2, 0, 4'b0000, 0, 0, 4'b0010, 0, 0));
    tv.push_back(v(0, 1, 0, 3'd1, 0, 4'b1001, 0, 0, 4'b1001, 0, 0));
    tv.push_back(v(0, 1, 0, 3'd5, 0, 4'b0000, 0, 0, 4'b1100, 0, 0));
    tv.push_back(v(0, 1, 0, 3'd1, 0, 4'b1001, 0, 0, 4'b1001, 0, 0));
    tv.push_back(v(0, 1, 0, 3'd3, 0, 4'b0000, 1, 0, 4'b1100, 0, 0));
    tv.push_back(v(0, 1, 0, 3'd1, 0, 4'b0001, 0, 0, 4'b0001, 0, 0));
    tv.push_back(v(0, 0, 1, 3'd4, 3, 4'b0000, 0, 0, 4'b0001, 1, 0));
    tv.push_back(v(0, 1, 0, 3'd1, 0, 4'b1111, 0, 0, 4'b0010, 1, 0));
    tv.push_back(v(0, 1, 1, 3'd1, 0, 4'b1111, 0, 0, 4'b0100, 1, 0));
    tv.push_back(v(0, 0, 0, 3'd0, 0, 4'b0000, 0, 0, 4'b1000, 0, 1));
    tv.push_back(v(0, 0, 0, 3'd0, 0, 4'b0000, 0, 0, 4'b1000, 0, 0));
    tv.push_back(v(0, 0, 1, 3'd4, 0, 4'b0000, 0, 0, 4'b1000, 0, 1));
    tv.push_back(v(0, 0, 0, 3'd0, 0, 4'b0000, 0, 0, 4'b1000, 0, 0));
    tv.push_back(v(0, 1, 0, 3'd1, 0, 4'b1011, 0, 0, 4'b1011, 0, 0));
    tv.push_back(v(0, 0, 1, 3'd4, 7, 4'b0000, 0, 0, 4'b1011, 1, 0));
    tv.push_back(v(0, 0, 0, 3'd0, 0, 4'b0000, 0, 0, 4'b0111, 1, 0));
    tv.push_back(v(0, 0, 0, 3'd0, 0, 4'b0000, 0, 0, 4'b1110, 1, 0));
    tv.push_back(v(0, 0, 0, 3'd0, 0, 4'b0000, 0, 0, 4'b1101, 1, 0));
    tv.push_back(v(0, 0, 0, 3'd0, 0, 4'b0000, 0, 0, 4'b1011, 0, 1));
    tv.push_back(v(0, 1, 0, 3'd1, 0, 4'b0001, 0, 0, 4'b0001, 0, 0));
    tv.push_back(v(0, 0, 1, 3'd2, 3, 4'b0000, 0, 0, 4'b0001, 1, 0));
    tv.push_back(v(0, 0, 0, 3'd0, 0, 4'b0000, 0, 0, 4'b0010, 1, 0));
    tv.push_back(v(1, 0, 0, 3'd0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0));
    tv.push_back(v(0, 0, 0, 3'd0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0));
    foreach (tv[i]) begin
      drv(tv[i].sclr, tv[i].en, tv[i].start, tv[i].mode, tv[i].amt, tv[i].d, tv[i].sl, tv[i].sr);
      tick();
      chk_state($sformatf("vec%0d", i), tv[i].q, tv[i].busy, tv[i].done);
      chk($sformatf("vec%0d.sout", i), {6'd0, bus.sout_l, bus.sout_r}, {6'd0, tv[i].q[3], tv[i].q[0]});
    end
    drv(0, 1, 0, 3'd1, 0, 4'b1000, 0, 0);
    tick();
    drv(0, 0, 1, 3'd6, 2, 4'b0000, 0, 0);
    tick();
`ifdef SHIFT_REG_ASR_EN
    chk_state("asr.e0", 4'b1000, 1, 0);
    drv(0, 0, 0, 3'd0, 0, 4'b0000, 0, 0);
    tick();
    chk_state("asr.e1", 4'b1100, 1, 0);
    tick();
    chk_state("asr.e2", 4'b1110, 0, 1);
`else
    chk_state("asr.e1", 4'b1000, 0, 1);
    drv(0, 0, 0, 3'd0, 0, 4'b0000, 0, 0);
    tick();
    chk_state("asr.e2", 4'b1000, 0, 0);
`endif
    drv(0, 1, 0, 3'd1, 0, 4'b0011, 0, 0);
    tick();
    drv(0, 0, 1, 3'd2, 3, 4'b0000, 0, 0);
    tick();
    drv(0, 0, 0, 3'd0, 0, 4'b0000, 0, 0);
    tick();
    chk_state("arst.pre", 4'b0110, 1, 0);
    #2 clr_n = 1'b0;
    #1;
    chk_state("arst.now", 4'b0000, 0, 0);
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state($sformatf("arst.after%0d", i), 4'b0000, 0, 0);
    end
    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(0, 19) == 0, 1'($urandom), $urandom_range(0, 5) == 0, 3'($urandom),
          3'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      tick();
      chk($sformatf("rnd%0d.Q", i), 8'(bus.Q), 8'(m_q));
      chk($sformatf("rnd%0d.busy", i), 8'(bus.busy), 8'(m_left > 0));
      chk($sformatf("rnd%0d.done", i), 8'(bus.done), 8'(m_done));
      chk($sformatf("rnd%0d.sout", i), {6'd0, bus.sout_l, bus.sout_r}, 8'(((m_q >> (W - 1)) << 1) | (m_q & 1)));
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
